// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry result queue toward writeback, NZCV flags
// register and per-op condition evaluation producing the write enable.
//
// Ports:
//   Clock, Resetn       clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready = count != 2)
//   in_result, in_rd    ALU result and destination register
//   in_zf/cf/of/nf      ALU flags for this result
//   in_setflags         op updates the flags register if its cond passes
//   in_cond             4-bit condition code
//   out_valid/out_ready writeback handshake
//   out_result, out_rd  head entry payload
//   out_wen             head condition result
//   flags               architectural flags {N,Z,C,V}
module alu_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_zf,
    input  logic             in_cf,
    input  logic             in_of,
    input  logic             in_nf,
    input  logic             in_setflags,
    input  logic [3:0]       in_cond,
    input  logic [3:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_rd,
    output logic             out_wen,
    output logic [3:0]       flags
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [3:0]       rd;
        logic             wen;
    } entry_t;

    logic [1:0] count_q, count_d;
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    entry_t     mem_q [2];
    entry_t     mem_d [2];
    entry_t     out_q, out_d;
    logic [3:0] flags_q, flags_d;

    logic accept;
    logic pop;
    logic cond_pass;
    logic fn, fz, fc, fv;

    assign {fn, fz, fc, fv} = flags_q;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Condition sees the flags before this op's own update.
    always_comb begin
        cond_pass = 1'b0;
        unique case (in_cond)
            4'd0:  cond_pass = 1'b1;
            4'd1:  cond_pass = fz;
            4'd2:  cond_pass = ~fz;
            4'd3:  cond_pass = fc;
            4'd4:  cond_pass = ~fc;
            4'd5:  cond_pass = fn;
            4'd6:  cond_pass = ~fn;
            4'd7:  cond_pass = fv;
            4'd8:  cond_pass = ~fv;
            4'd9:  cond_pass = fc & ~fz;
            4'd10: cond_pass = ~fc | fz;
            4'd11: cond_pass = (fn == fv);
            4'd12: cond_pass = (fn != fv);
            4'd13: cond_pass = ~fz & (fn == fv);
            4'd14: cond_pass = fz | (fn != fv);
            4'd15: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q ^ pop;
        tail_d  = tail_q ^ accept;
        mem_d   = mem_q;
        out_d   = out_q;
        flags_d = flags_q;

        unique case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (accept) begin
            mem_d[tail_q].result = in_result;
            mem_d[tail_q].rd     = in_rd;
            mem_d[tail_q].wen    = cond_pass;
        end

        // Head outputs are registered: load the entry that will be at the
        // head after this edge, or hold the last one when the queue drains.
        if (count_d != 2'd0) begin
            out_d = mem_d[head_d];
        end

        if (accept && in_setflags && cond_pass) begin
            flags_d = {in_nf, in_zf, in_cf, in_of};
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            mem_q   <= '{default: '0};
            out_q   <= '0;
            flags_q <= 4'b0000;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            mem_q   <= mem_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign out_result = out_q.result;
    assign out_rd     = out_q.rd;
    assign out_wen    = out_q.wen;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: condition table plus
// backpressure, streaming and asynchronous reset sequences.
module tb_alu_result_stage;

    localparam logic [3:0] AL = 4'd0, EQ = 4'd1, NE = 4'd2, CS = 4'd3;
    localparam logic [3:0] CC = 4'd4, MI = 4'd5, PL = 4'd6, VS = 4'd7;
    localparam logic [3:0] VC = 4'd8, HI = 4'd9, LS = 4'd10, GE = 4'd11;
    localparam logic [3:0] LT = 4'd12, GT = 4'd13, LE = 4'd14, NV = 4'd15;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic        in_zf = 1'b0, in_cf = 1'b0, in_of = 1'b0, in_nf = 1'b0;
    logic        in_setflags = 1'b0;
    logic [3:0]  in_cond = '0;
    logic [3:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_wen;
    logic [3:0]  flags;

    alu_result_stage #(.WIDTH(32)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result),
        .in_zf(in_zf), .in_cf(in_cf), .in_of(in_of), .in_nf(in_nf),
        .in_setflags(in_setflags), .in_cond(in_cond), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
        .flags(flags)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  rd;
        logic [3:0]  cond;
        logic        sf;
        logic [3:0]  fl;
        logic        ewen;
        logic [3:0]  eflags;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    function automatic void add(input logic [31:0] res, input logic [3:0] rd,
                                input logic [3:0] cond, input logic sf,
                                input logic [3:0] fl, input logic ewen,
                                input logic [3:0] eflags);
        vec_t v;
        v.res = res; v.rd = rd; v.cond = cond; v.sf = sf;
        v.fl = fl; v.ewen = ewen; v.eflags = eflags;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic drive(input logic v, input logic [31:0] res,
                         input logic [3:0] rd, input logic [3:0] cond,
                         input logic sf, input logic [3:0] fl);
        in_valid = v; in_result = res; in_rd = rd; in_cond = cond;
        in_setflags = sf;
        {in_nf, in_zf, in_cf, in_of} = fl;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        // Condition table; flags column is {N,Z,C,V}, expected flags
        // are the register value after that op's accept edge.
        add(32'h5,  4'd3,  AL, 1, 4'b0000, 1, 4'b0000);
        add(32'h20, 4'd1,  AL, 1, 4'b0100, 1, 4'b0100);
        add(32'h21, 4'd2,  EQ, 0, 4'b0000, 1, 4'b0100);
        add(32'h22, 4'd4,  NE, 0, 4'b0000, 0, 4'b0100);
        add(32'h23, 4'd5,  NE, 1, 4'b1000, 0, 4'b0100);
        add(32'h24, 4'd6,  CS, 0, 4'b0000, 0, 4'b0100);
        add(32'h25, 4'd7,  AL, 1, 4'b1000, 1, 4'b1000);
        add(32'h26, 4'd8,  GE, 0, 4'b0000, 0, 4'b1000);
        add(32'h27, 4'd9,  LT, 0, 4'b0000, 1, 4'b1000);
        add(32'h28, 4'd10, LE, 0, 4'b0000, 1, 4'b1000);
        add(32'h29, 4'd11, GT, 0, 4'b0000, 0, 4'b1000);
        add(32'h2a, 4'd12, MI, 0, 4'b0000, 1, 4'b1000);
        add(32'h2b, 4'd13, PL, 0, 4'b0000, 0, 4'b1000);
        add(32'h2c, 4'd14, AL, 1, 4'b1011, 1, 4'b1011);
        add(32'h2d, 4'd15, HI, 0, 4'b0000, 1, 4'b1011);
        add(32'h2e, 4'd0,  LS, 0, 4'b0000, 0, 4'b1011);
        add(32'h2f, 4'd1,  VS, 0, 4'b0000, 1, 4'b1011);
        add(32'h30, 4'd2,  VC, 0, 4'b0000, 0, 4'b1011);
        add(32'h31, 4'd3,  GE, 0, 4'b0000, 1, 4'b1011);
        add(32'h32, 4'd4,  GT, 0, 4'b0000, 1, 4'b1011);
        add(32'h33, 4'd5,  CC, 0, 4'b0000, 0, 4'b1011);
        add(32'h34, 4'd6,  LT, 0, 4'b0000, 0, 4'b1011);
        add(32'h35, 4'd7,  NV, 1, 4'b0000, 0, 4'b1011);
        add(32'h36, 4'd8,  AL, 1, 4'b0100, 1, 4'b0100);
        add(32'h37, 4'd9,  HI, 0, 4'b0000, 0, 4'b0100);
        add(32'h38, 4'd10, LS, 0, 4'b0000, 1, 4'b0100);
        add(32'h39, 4'd11, GT, 0, 4'b0000, 0, 4'b0100);
        add(32'h3a, 4'd12, LE, 0, 4'b0000, 1, 4'b0100);
        add(32'h3b, 4'd13, EQ, 1, 4'b0010, 1, 4'b0010);
        add(32'h3c, 4'd14, CS, 0, 4'b0000, 1, 4'b0010);

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_wen", 32'(out_wen), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        Resetn = 1'b1;
        step();

        // Back-to-back table ops with out_ready high
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].res, vecs[i].rd, vecs[i].cond,
                  vecs[i].sf, vecs[i].fl);
            step();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
            chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d_wen", i), 32'(out_wen), 32'(vecs[i].ewen));
            chk($sformatf("v%0d_flags", i), 32'(flags),
                32'(vecs[i].eflags));
        end
        drive(1'b0, '0, '0, AL, 1'b0, 4'b0000);
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_hold_result", out_result, 32'h3c);
        chk("drain_in_ready", 32'(in_ready), 32'd1);

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 4'd1, AL, 1'b0, 4'b0000);
        step();
        chk("bp1_ready", 32'(in_ready), 32'd1);
        chk("bp1_result", out_result, 32'h11);
        drive(1'b1, 32'h22, 4'd2, AL, 1'b0, 4'b0000);
        step();
        chk("bp2_ready", 32'(in_ready), 32'd0);
        chk("bp2_hold", out_result, 32'h11);
        drive(1'b1, 32'h33, 4'd3, AL, 1'b0, 4'b0000);
        step();
        chk("bp3_ready", 32'(in_ready), 32'd0);
        chk("bp3_hold", out_result, 32'h11);
        chk("bp3_hold_rd", 32'(out_rd), 32'd1);
        drive(1'b0, '0, '0, AL, 1'b0, 4'b0000);
        out_ready = 1'b1;
        step();
        chk("bp_pop1_result", out_result, 32'h22);
        chk("bp_pop1_valid", 32'(out_valid), 32'd1);
        chk("bp_pop1_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_pop2_valid", 32'(out_valid), 32'd0);

        // Full-throughput stream 1..8
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 4'(i), AL, 1'b0, 4'b0000);
            step();
            chk($sformatf("st%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("st%0d_result", i), out_result, 32'(i));
        end
        drive(1'b0, '0, '0, AL, 1'b0, 4'b0000);
        step();
        chk("st_end_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset with two entries queued
        out_ready = 1'b0;
        drive(1'b1, 32'haa, 4'd9, AL, 1'b1, 4'b1111);
        step();
        drive(1'b1, 32'hbb, 4'd10, AL, 1'b0, 4'b0000);
        step();
        drive(1'b0, '0, '0, AL, 1'b0, 4'b0000);
        chk("mid_full", 32'(in_ready), 32'd0);
        chk("mid_flags", 32'(flags), 32'hf);
        Resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_flags", 32'(flags), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_result", out_result, 32'd0);
        #2;
        Resetn = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
